// File: rtl/rpn_pkg.sv
// Shared types for the RPN stack calculator: opcodes, FSM states and the saturation helper.
package rpn_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned WIDE_W = 64;

  typedef enum logic [OP_W-1:0] {
    NOP  = 3'd0,
    NEG  = 3'd1,
    ADD  = 3'd2,
    SUB  = 3'd3,
    MUL  = 3'd4,
    SWAP = 3'd5,
    DUP  = 3'd6,
    DROP = 3'd7
  } op_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  // Clamp a wide signed value into the signed range of a w-bit word (w <= 32).
  function automatic logic signed [WIDE_W-1:0] sat_signed(
    input logic signed [WIDE_W-1:0] x,
    input int unsigned              w
  );
    logic signed [WIDE_W-1:0] one;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    one = WIDE_W'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = -hi - one;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/rpn_stack_ram.sv
// Backing store for stack entries below TOS/NOS: one sync write port, one sync read port.
module rpn_stack_ram #(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned WORDS  = 1022,
  localparam int unsigned ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rpn_stack_calc.sv
// RPN stack calculator: TOS/NOS in registers, deeper entries in rpn_stack_ram.
// Define SAT_ARITH_EN for saturating NEG/ADD/SUB/MUL; otherwise arithmetic wraps.
module rpn_stack_calc
  import rpn_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned DEPTH  = 1024,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     cmd_vld,
  output logic                     cmd_rdy,
  input  logic                     push,
  input  logic signed [DATA_W-1:0] d,
  input  op_t                      op,
  input  logic                     err_clr,
  output logic signed [DATA_W-1:0] top,
  output logic [CNT_W-1:0]         cnt,
  output logic                     ovf,
  output logic                     unf
);

  localparam int unsigned RAM_WORDS = DEPTH - 2;
  localparam int unsigned ADDR_W    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  state_t                     state, state_n;
  logic signed [DATA_W-1:0]   nos, nos_n, top_n, alu;
  logic [CNT_W-1:0]           cnt_n;
  logic                       ovf_n, unf_n, rdy_n, accept, pop;
  logic                       ram_we, ram_re;
  logic [ADDR_W-1:0]          ram_waddr, ram_raddr;
  logic [DATA_W-1:0]          ram_rdata;
  logic signed [WIDE_W-1:0]   a_w, b_w, alu_w;

  assign accept = cmd_vld & cmd_rdy;

  rpn_stack_ram #(
    .DATA_W (DATA_W),
    .WORDS  (RAM_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (nos),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // ALU: computed wide so that saturation sees the true result.
  always_comb begin
    a_w   = WIDE_W'(nos);
    b_w   = WIDE_W'(top);
    alu_w = b_w;
    case (op)
      NEG:     alu_w = -b_w;
      ADD:     alu_w = a_w + b_w;
      SUB:     alu_w = a_w - b_w;
      MUL:     alu_w = a_w * b_w;
      default: alu_w = b_w;
    endcase
`ifdef SAT_ARITH_EN
    alu = DATA_W'(sat_signed(alu_w, DATA_W));
`else
    alu = DATA_W'(alu_w);
`endif
  end

  // Next-state and stack update logic.
  always_comb begin
    state_n   = state;
    top_n     = top;
    nos_n     = nos;
    cnt_n     = cnt;
    ovf_n     = ovf;
    unf_n     = unf;
    pop       = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = ADDR_W'(cnt - CNT_W'(2));
    ram_raddr = ADDR_W'(cnt - CNT_W'(3));
    case (state)
      IDLE: begin
        if (accept) begin
          if (push || op == DUP) begin
            // DUP of an empty stack has no operand and counts as underflow.
            if (!push && cnt == '0) begin
              unf_n = 1'b1;
            end else if (cnt == CNT_W'(DEPTH)) begin
              ovf_n = 1'b1;
            end else begin
              ram_we = (cnt >= CNT_W'(2));
              nos_n  = top;
              top_n  = push ? d : top;
              cnt_n  = cnt + CNT_W'(1);
            end
          end else begin
            case (op)
              NEG: begin
                if (cnt >= CNT_W'(1)) top_n = alu;
                else                  unf_n = 1'b1;
              end
              ADD, SUB, MUL: begin
                if (cnt >= CNT_W'(2)) begin
                  top_n = alu;
                  pop   = 1'b1;
                end else begin
                  unf_n = 1'b1;
                end
              end
              SWAP: begin
                if (cnt >= CNT_W'(2)) begin
                  top_n = nos;
                  nos_n = top;
                end else begin
                  unf_n = 1'b1;
                end
              end
              DROP: begin
                if (cnt >= CNT_W'(1)) begin
                  top_n = (cnt == CNT_W'(1)) ? '0 : nos;
                  pop   = 1'b1;
                end else begin
                  unf_n = 1'b1;
                end
              end
              default: ;
            endcase
            if (pop) begin
              cnt_n = cnt - CNT_W'(1);
              if (cnt >= CNT_W'(3)) begin
                ram_re  = 1'b1;
                state_n = REFILL;
              end else begin
                nos_n = '0;
              end
            end
          end
        end
      end
      REFILL: begin
        nos_n   = ram_rdata;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (err_clr) begin
      ovf_n = 1'b0;
      unf_n = 1'b0;
    end
    rdy_n = (state_n == IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      top     <= '0;
      nos     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      cmd_rdy <= 1'b1;
    end else begin
      state   <= state_n;
      top     <= top_n;
      nos     <= nos_n;
      cnt     <= cnt_n;
      ovf     <= ovf_n;
      unf     <= unf_n;
      cmd_rdy <= rdy_n;
    end
  end

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Bench for rpn_stack_calc: directed vector table, fill/drain and reset sequences,
// then random commands checked against a queue-based stack model.
module tb_rpn_stack_calc;
  import rpn_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int          SMAX  = (1 <<< (DW - 1)) - 1;
  localparam int          SMIN  = -(1 <<< (DW - 1));

`ifdef SAT_ARITH_EN
  localparam int E_ADD  = SMAX;
  localparam int E_NEG1 = -SMAX;
  localparam int E_MUL  = SMAX;
  localparam int E_NEGM = SMAX;
`else
  localparam int E_ADD  = SMIN;
  localparam int E_NEG1 = SMIN;
  localparam int E_MUL  = 0;
  localparam int E_NEGM = SMIN;
`endif

  logic                 clk = 1'b0;
  logic                 nrst;
  logic                 cmd_vld;
  logic                 cmd_rdy;
  logic                 push;
  logic signed [DW-1:0] d;
  op_t                  op;
  logic                 err_clr;
  logic signed [DW-1:0] top;
  logic [CW-1:0]        cnt;
  logic                 ovf;
  logic                 unf;

  int checks = 0;
  int errors = 0;

  int q[$];
  bit m_ovf, m_unf;

  typedef struct {
    logic p;
    int   v;
    op_t  o;
    logic clr;
    int   e_top;
    int   e_cnt;
    logic e_ovf;
    logic e_unf;
    logic e_rdy;
  } vec_t;

  vec_t tbl[$];

  rpn_stack_calc #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .cmd_vld (cmd_vld),
    .cmd_rdy (cmd_rdy),
    .push    (push),
    .d       (d),
    .op      (op),
    .err_clr (err_clr),
    .top     (top),
    .cnt     (cnt),
    .ovf     (ovf),
    .unf     (unf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic p, input int v, input op_t o, input logic clr,
                              input int et, input int ec, input logic eo, input logic eu,
                              input logic er);
    vec_t r;
    r.p = p; r.v = v; r.o = o; r.clr = clr;
    r.e_top = et; r.e_cnt = ec; r.e_ovf = eo; r.e_unf = eu; r.e_rdy = er;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int et, input int ec, input logic eo,
                         input logic eu, input logic er);
    chk({tag, " top"}, int'(top), et);
    chk({tag, " cnt"}, int'(cnt), ec);
    chk({tag, " ovf"}, int'(ovf), int'(eo));
    chk({tag, " unf"}, int'(unf), int'(eu));
    chk({tag, " cmd_rdy"}, int'(cmd_rdy), int'(er));
  endtask

  // Called at a negedge; presents one cycle of inputs and returns at the next negedge.
  task automatic drive(input logic vld, input logic p, input int v, input op_t o, input logic clr);
    cmd_vld = vld; push = p; d = DW'(v); op = o; err_clr = clr;
    @(negedge clk);
    cmd_vld = 1'b0; push = 1'b0; op = NOP; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  function automatic int arith(input op_t o, input int a, input int b);
    longint r;
`ifndef SAT_ARITH_EN
    logic signed [DW-1:0] t;
`endif
    case (o)
      NEG:     r = -longint'(b);
      ADD:     r = longint'(a) + longint'(b);
      SUB:     r = longint'(a) - longint'(b);
      MUL:     r = longint'(a) * longint'(b);
      default: r = longint'(b);
    endcase
`ifdef SAT_ARITH_EN
    if (r > SMAX) r = SMAX;
    else if (r < SMIN) r = SMIN;
    return int'(r);
`else
    t = DW'(r);
    return int'(t);
`endif
  endfunction

  // Stack model: q[0] is the top of stack.
  task automatic model_step(input bit vld, input bit p, input int v, input op_t o,
                            input bit clr, output bit refill);
    bit so, su;
    int n, r, t;
    so = 0; su = 0; refill = 0;
    n = q.size();
    if (vld) begin
      if (p || o == DUP) begin
        if (!p && n == 0) su = 1;
        else if (n == DEPTH) so = 1;
        else q.push_front(p ? v : q[0]);
      end else begin
        case (o)
          NEG: if (n < 1) su = 1; else q[0] = arith(NEG, 0, q[0]);
          ADD, SUB, MUL: begin
            if (n < 2) su = 1;
            else begin
              r = arith(o, q[1], q[0]);
              void'(q.pop_front());
              q[0] = r;
              refill = (n >= 3);
            end
          end
          SWAP: begin
            if (n < 2) su = 1;
            else begin
              t = q[0]; q[0] = q[1]; q[1] = t;
            end
          end
          DROP: begin
            if (n < 1) su = 1;
            else begin
              void'(q.pop_front());
              refill = (n >= 3);
            end
          end
          default: ;
        endcase
      end
    end
    m_ovf = clr ? 1'b0 : (m_ovf | so);
    m_unf = clr ? 1'b0 : (m_unf | su);
  endtask

  task automatic chk_model(input string tag, input bit refill);
    chk_all(tag, (q.size() > 0) ? q[0] : 0, q.size(), m_ovf, m_unf, !refill);
  endtask

  initial begin
    nrst = 1'b1; cmd_vld = 1'b0; push = 1'b0; d = '0; op = NOP; err_clr = 1'b0;
    #1 nrst = 1'b0;
    #1;
    chk_all("reset", 0, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    nrst = 1'b1;

    // Directed vectors from reset: {push, d, op, clr, top, cnt, ovf, unf, cmd_rdy}
    tbl.push_back(mk(1, 3,     NOP,  0, 3,      1, 0, 0, 1));
    tbl.push_back(mk(1, 4,     NOP,  0, 4,      2, 0, 0, 1));
    tbl.push_back(mk(0, 0,     ADD,  0, 7,      1, 0, 0, 1));
    tbl.push_back(mk(0, 0,     DROP, 0, 0,      0, 0, 0, 1));
    tbl.push_back(mk(1, 5,     NOP,  0, 5,      1, 0, 0, 1));
    tbl.push_back(mk(1, 6,     NOP,  0, 6,      2, 0, 0, 1));
    tbl.push_back(mk(1, 7,     NOP,  0, 7,      3, 0, 0, 1));
    tbl.push_back(mk(0, 0,     MUL,  0, 42,     2, 0, 0, 0));
    tbl.push_back(mk(0, 0,     SUB,  0, -37,    1, 0, 0, 1));
    tbl.push_back(mk(0, 0,     DROP, 0, 0,      0, 0, 0, 1));
    tbl.push_back(mk(0, 0,     ADD,  0, 0,      0, 0, 1, 1));
    tbl.push_back(mk(1, 9,     NOP,  0, 9,      1, 0, 1, 1));
    tbl.push_back(mk(0, 0,     SWAP, 0, 9,      1, 0, 1, 1));
    tbl.push_back(mk(0, 0,     NOP,  1, 9,      1, 0, 0, 1));
    tbl.push_back(mk(0, 0,     ADD,  0, 9,      1, 0, 1, 1));
    tbl.push_back(mk(0, 0,     ADD,  1, 9,      1, 0, 0, 1));
    tbl.push_back(mk(0, 0,     DROP, 0, 0,      0, 0, 0, 1));
    tbl.push_back(mk(1, 32767, NOP,  0, 32767,  1, 0, 0, 1));
    tbl.push_back(mk(1, 1,     NOP,  0, 1,      2, 0, 0, 1));
    tbl.push_back(mk(0, 0,     ADD,  0, E_ADD,  1, 0, 0, 1));
    tbl.push_back(mk(0, 0,     NEG,  0, E_NEG1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,     DUP,  0, E_NEG1, 2, 0, 0, 1));
    tbl.push_back(mk(0, 0,     MUL,  0, E_MUL,  1, 0, 0, 1));
    tbl.push_back(mk(0, 0,     DROP, 0, 0,      0, 0, 0, 1));
    tbl.push_back(mk(1, SMIN,  NOP,  0, SMIN,   1, 0, 0, 1));
    tbl.push_back(mk(0, 0,     NEG,  0, E_NEGM, 1, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(1'b1, tbl[i].p, tbl[i].v, tbl[i].o, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].e_top, tbl[i].e_cnt, tbl[i].e_ovf,
              tbl[i].e_unf, tbl[i].e_rdy);
      if (!tbl[i].e_rdy) begin
        drive(1'b0, 1'b0, 0, NOP, 1'b0);
        chk_all($sformatf("vec%0d refill", i), tbl[i].e_top, tbl[i].e_cnt, tbl[i].e_ovf,
                tbl[i].e_unf, 1'b1);
      end
    end

    // Fill to DEPTH, overflow, clear, then drain checking every RAM entry comes back.
    do_reset();
    for (int k = 1; k <= DEPTH; k++) drive(1'b1, 1'b1, k, NOP, 1'b0);
    chk_all("full", DEPTH, DEPTH, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 99, NOP, 1'b0);
    chk_all("ovf push", DEPTH, DEPTH, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 0, DUP, 1'b0);
    chk_all("ovf dup", DEPTH, DEPTH, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 0, NOP, 1'b1);
    chk_all("ovf clr", DEPTH, DEPTH, 1'b0, 1'b0, 1'b1);
    for (int k = DEPTH; k >= 1; k--) begin
      drive(1'b1, 1'b0, 0, DROP, 1'b0);
      chk($sformatf("drain%0d top", k), int'(top), k - 1);
      chk($sformatf("drain%0d cnt", k), int'(cnt), k - 1);
      if (k >= 3) drive(1'b0, 1'b0, 0, NOP, 1'b0);
    end

    // Reset asserted while a REFILL is in flight.
    do_reset();
    drive(1'b1, 1'b0, 0, ADD, 1'b0);
    drive(1'b1, 1'b1, 1, NOP, 1'b0);
    drive(1'b1, 1'b1, 2, NOP, 1'b0);
    drive(1'b1, 1'b1, 3, NOP, 1'b0);
    drive(1'b1, 1'b0, 0, DROP, 1'b0);
    chk_all("pre-rst refill", 2, 2, 1'b0, 1'b1, 1'b0);
    nrst = 1'b0;
    #1;
    chk_all("rst in refill", 0, 0, 1'b0, 1'b0, 1'b1);
    #2 nrst = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b1, 8, NOP, 1'b0);
    chk_all("push after rst", 8, 1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 0, DROP, 1'b0);
    chk_all("drop after rst", 0, 0, 1'b0, 1'b0, 1'b1);

    // Random commands against the model, with junk commands offered during REFILL.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit vld, p, clr, rf, jrf;
      int v, n;
      op_t o;
      logic signed [DW-1:0] r16;
      n   = q.size();
      vld = ($urandom_range(0, 7) != 0);
      p   = (n < 3) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 4);
      r16 = DW'($urandom);
      v   = ($urandom_range(0, 3) == 0) ? int'(r16) : (int'($urandom_range(0, 40)) - 20);
      o   = op_t'(3'($urandom_range(0, 7)));
      clr = ($urandom_range(0, 15) == 0);
      model_step(vld, p, v, o, clr, rf);
      drive(vld, p, v, o, clr);
      chk_model($sformatf("rnd%0d", i), rf);
      if (rf) begin
        jrf = 0;
        r16 = DW'($urandom);
        drive(1'b1, 1'($urandom_range(0, 1)), int'(r16), op_t'(3'($urandom_range(0, 7))), 1'b0);
        chk_model($sformatf("rnd%0d refill", i), jrf);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
